// File: rtl/gps2utc_pkg.sv
// Shared constants, FSM state type and calendar/BCD helpers for the sequential GPS->UTC converter.
package gps2utc_pkg;

    localparam logic [31:0] SEC_WEEK   = 32'd604800;
    localparam logic [16:0] SEC_DAY    = 17'd86400;
    localparam logic [19:0] TOW_MAX    = 20'd604799;
    localparam logic [15:0] EPOCH_YEAR = 16'd1980;
    // GPS day 0 is 6 January, i.e. zero-based day 5 of the epoch year
    localparam logic [14:0] EPOCH_DOY0 = 15'd5;
    localparam logic [31:0] EPOCH_JD   = 32'd2444245;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_HMS  = 3'd3,
        ST_YEAR = 3'd4,
        ST_MON  = 3'd5,
        ST_BCD  = 3'd6,
        ST_DONE = 3'd7
    } state_e;

    function automatic logic is_leap(input logic [15:0] y);
        return ((y % 16'd4) == 16'd0) &&
               (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
    endfunction

    function automatic logic [14:0] year_len(input logic [15:0] y);
        return is_leap(y) ? 15'd366 : 15'd365;
    endfunction

    function automatic logic [14:0] month_len(input logic [3:0] m, input logic leap);
        logic [14:0] len;
        case (m)
            4'd2:    len = leap ? 15'd29 : 15'd28;
            4'd4:    len = 15'd30;
            4'd6:    len = 15'd30;
            4'd9:    len = 15'd30;
            4'd11:   len = 15'd30;
            default: len = 15'd31;
        endcase
        return len;
    endfunction

    function automatic logic [7:0] bcd2(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    function automatic logic [11:0] bcd3(input logic [11:0] v);
        return {4'(v / 12'd100), 4'((v / 12'd10) % 12'd10), 4'(v % 12'd10)};
    endfunction

endpackage

// File: rtl/gps2utc_div32.sv
// Sequential 32/17 restoring divider: the first step happens with the start pulse, done
// is a one-cycle pulse after 32 steps; quotient/remainder hold until the next start.
import gps2utc_pkg::*;

module gps2utc_div32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [16:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quot,
    output logic [16:0] o_rem
);

    logic [31:0] r_q;
    logic [16:0] r_rem;
    logic [16:0] r_dvs;
    logic [4:0]  r_cnt;
    logic        r_run;
    logic        r_done;

    logic [31:0] w_q_in;
    logic [16:0] w_rem_in;
    logic [16:0] w_dvs_in;
    logic [17:0] w_trial;
    logic        w_ge;
    logic [16:0] w_rem_nx;
    logic [31:0] w_q_nx;

    // One shift/subtract step on either the fresh operands or the running state
    always_comb begin
        w_q_in   = i_start ? i_dividend : r_q;
        w_rem_in = i_start ? 17'd0      : r_rem;
        w_dvs_in = i_start ? i_divisor  : r_dvs;
        w_trial  = {w_rem_in, w_q_in[31]};
        w_ge     = (w_trial >= {1'b0, w_dvs_in});
        if (w_ge) begin
            w_rem_nx = 17'(w_trial - {1'b0, w_dvs_in});
        end else begin
            w_rem_nx = w_trial[16:0];
        end
        w_q_nx = {w_q_in[30:0], w_ge};
    end

    // Iteration state and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= 32'd0;
            r_rem  <= 17'd0;
            r_dvs  <= 17'd0;
            r_cnt  <= 5'd0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_q   <= w_q_nx;
                r_rem <= w_rem_nx;
                r_dvs <= i_divisor;
                r_cnt <= 5'd1;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_q   <= w_q_nx;
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_q;
    assign o_rem  = r_rem;

endmodule

// File: rtl/gps2utc_seq.sv
// GPS WN10/TOW -> UTC calendar converter: divider for days/second-of-day, then year and month walks.
// Optional macro GPS2UTC_BCD_EN: BCD output fields via an extra BCD state.
import gps2utc_pkg::*;

module gps2utc_seq #(
    parameter logic [1:0] EPOCH_INDEX = 2'd2,
    parameter logic [9:0] ROLL_PIVOT  = 10'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  wn10,
    input  logic [19:0] tow_sec,
    input  logic [7:0]  leap_sec,
    output logic        busy,
    output logic        valid,
    output logic        err,
    output logic [7:0]  hh,
    output logic [7:0]  mm,
    output logic [7:0]  ss,
    output logic [7:0]  mon,
    output logic [7:0]  dom,
    output logic [11:0] doy,
    output logic [7:0]  yy,
    output logic [15:0] year
);

    state_e      r_state, w_state_nx;
    logic [9:0]  r_wn10;
    logic [19:0] r_tow;
    logic [7:0]  r_leap;
    logic [1:0]  r_epoch;
    logic [1:0]  w_epoch_sel;

    logic [31:0] w_gps_s, w_utc_s;
    logic        w_load_err;
    logic        w_div_start, w_div_done, w_days_ovf;
    logic [31:0] w_quot;
    logic [16:0] w_sod;

    logic [7:0]  r_hh_w, r_mm_w, r_ss_w;
    logic [11:0] r_doy_w;
    logic [14:0] r_rem;
    logic [15:0] r_y;
    logic [3:0]  r_m;
    logic [14:0] w_ylen, w_mlen;
    logic        w_y_ge, w_m_ge;

    logic        w_latch_in, w_fin, w_fin_err;
    logic        r_busy, r_valid, r_err;
    logic [7:0]  r_hh, r_mm, r_ss, r_mon, r_dom, r_yy;
    logic [11:0] r_doy;
    logic [15:0] r_year;

    function automatic logic [7:0] fmt2(input logic [7:0] v);
`ifdef GPS2UTC_BCD_EN
        return bcd2(v);
`else
        return v;
`endif
    endfunction

    function automatic logic [11:0] fmt3(input logic [11:0] v);
`ifdef GPS2UTC_BCD_EN
        return bcd3(v);
`else
        return v;
`endif
    endfunction

    // Low week numbers past the pivot belong to the following 1024-week epoch
    generate
        if (ROLL_PIVOT == 10'd0) begin : g_no_roll
            assign w_epoch_sel = EPOCH_INDEX;
        end else begin : g_roll
            assign w_epoch_sel = (wn10 < ROLL_PIVOT) ?
                                 ((EPOCH_INDEX == 2'd3) ? 2'd3 : EPOCH_INDEX + 2'd1) :
                                 EPOCH_INDEX;
        end
    endgenerate

    assign w_gps_s    = 32'({r_epoch, r_wn10}) * SEC_WEEK + 32'(r_tow);
    assign w_utc_s    = w_gps_s - 32'(r_leap);
    assign w_load_err = (r_tow > TOW_MAX) || (w_gps_s < 32'(r_leap));
    assign w_days_ovf = |w_quot[31:15];
    assign w_ylen     = year_len(r_y);
    assign w_mlen     = month_len(r_m, is_leap(r_y));
    assign w_y_ge     = (r_rem >= w_ylen);
    assign w_m_ge     = (r_rem >= w_mlen);

    gps2utc_div32 u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_utc_s),
        .i_divisor  (SEC_DAY),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_sod)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (start)      w_state_nx = ST_LOAD; else w_state_nx = ST_IDLE;
            ST_LOAD: if (w_load_err) w_state_nx = ST_DONE; else w_state_nx = ST_DIV;
            ST_DIV:  if (w_div_done) w_state_nx = ST_HMS;  else w_state_nx = ST_DIV;
            ST_HMS:  if (w_days_ovf) w_state_nx = ST_DONE; else w_state_nx = ST_YEAR;
            ST_YEAR: if (w_y_ge)     w_state_nx = ST_YEAR; else w_state_nx = ST_MON;
            ST_MON: begin
                if (w_m_ge) begin
                    w_state_nx = ST_MON;
                end else begin
`ifdef GPS2UTC_BCD_EN
                    w_state_nx = ST_BCD;
`else
                    w_state_nx = ST_DONE;
`endif
                end
            end
            ST_BCD:  w_state_nx = ST_DONE;
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        w_latch_in  = (r_state == ST_IDLE) && start;
        w_div_start = (r_state == ST_LOAD) && !w_load_err;
        w_fin       = (w_state_nx == ST_DONE);
        w_fin_err   = (r_state == ST_LOAD) || (r_state == ST_HMS);
    end

    // Input capture and the working time-of-day / calendar walk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wn10  <= 10'd0;
            r_tow   <= 20'd0;
            r_leap  <= 8'd0;
            r_epoch <= 2'd0;
            r_hh_w  <= 8'd0;
            r_mm_w  <= 8'd0;
            r_ss_w  <= 8'd0;
            r_doy_w <= 12'd0;
            r_rem   <= 15'd0;
            r_y     <= 16'd0;
            r_m     <= 4'd0;
        end else begin
            if (w_latch_in) begin
                r_wn10  <= wn10;
                r_tow   <= tow_sec;
                r_leap  <= leap_sec;
                r_epoch <= w_epoch_sel;
            end
            case (r_state)
                ST_HMS: begin
                    r_hh_w <= 8'(w_sod / 17'd3600);
                    r_mm_w <= 8'((w_sod / 17'd60) % 17'd60);
                    r_ss_w <= 8'(w_sod % 17'd60);
                    r_rem  <= w_quot[14:0] + EPOCH_DOY0;
                    r_y    <= EPOCH_YEAR;
                end
                ST_YEAR: begin
                    if (w_y_ge) begin
                        r_rem <= r_rem - w_ylen;
                        r_y   <= r_y + 16'd1;
                    end else begin
                        r_doy_w <= 12'(r_rem) + 12'd1;
                        r_m     <= 4'd1;
                    end
                end
                ST_MON: begin
                    if (w_m_ge) begin
                        r_rem <= r_rem - w_mlen;
                        r_m   <= r_m + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered result fields; an error only raises err and leaves the time fields alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_hh    <= 8'd0;
            r_mm    <= 8'd0;
            r_ss    <= 8'd0;
            r_mon   <= 8'd0;
            r_dom   <= 8'd0;
            r_doy   <= 12'd0;
            r_yy    <= 8'd0;
            r_year  <= 16'd0;
        end else begin
            r_busy  <= (w_state_nx != ST_IDLE);
            r_valid <= w_fin;
            if (w_fin) begin
                if (w_fin_err) begin
                    r_err <= 1'b1;
                end else begin
                    r_err  <= 1'b0;
                    r_hh   <= fmt2(r_hh_w);
                    r_mm   <= fmt2(r_mm_w);
                    r_ss   <= fmt2(r_ss_w);
                    r_mon  <= fmt2(8'(r_m));
                    r_dom  <= fmt2(8'(r_rem) + 8'd1);
                    r_doy  <= fmt3(r_doy_w);
                    r_yy   <= fmt2(8'(r_y % 16'd100));
                    r_year <= r_y;
                end
            end
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign err   = r_err;
    assign hh    = r_hh;
    assign mm    = r_mm;
    assign ss    = r_ss;
    assign mon   = r_mon;
    assign dom   = r_dom;
    assign doy   = r_doy;
    assign yy    = r_yy;
    assign year  = r_year;

endmodule

// File: tb/tb_gps2utc_seq.sv
// Randomized and directed bench for gps2utc_seq: three instances (epoch 2, epoch 0, epoch 2 with
// rollover pivot 512) share the inputs and are checked against a civil-calendar reference model.
module tb_gps2utc_seq;

`ifdef GPS2UTC_BCD_EN
    localparam int BCD_LAT = 1;
`else
    localparam int BCD_LAT = 0;
`endif
    localparam int CYC_BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [9:0]  wn10;
    logic [19:0] tow_sec;
    logic [7:0]  leap_sec;

    logic        busy_o [3];
    logic        valid_o[3];
    logic        err_o  [3];
    logic [7:0]  hh_o[3], mm_o[3], ss_o[3], mon_o[3], dom_o[3], yy_o[3];
    logic [11:0] doy_o [3];
    logic [15:0] year_o[3];

    logic [75:0] exp_pack[3];
    logic        exp_err [3];
    int          exp_lat [3];
    int          lat_seen[3];
    int          n_vec = 0;
    int          n_err = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            gps2utc_seq #(
                .EPOCH_INDEX ((g == 1) ? 2'd0 : 2'd2),
                .ROLL_PIVOT  ((g == 2) ? 10'd512 : 10'd0)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .start    (start),
                .wn10     (wn10),
                .tow_sec  (tow_sec),
                .leap_sec (leap_sec),
                .busy     (busy_o[g]),
                .valid    (valid_o[g]),
                .err      (err_o[g]),
                .hh       (hh_o[g]),
                .mm       (mm_o[g]),
                .ss       (ss_o[g]),
                .mon      (mon_o[g]),
                .dom      (dom_o[g]),
                .doy      (doy_o[g]),
                .yy       (yy_o[g]),
                .year     (year_o[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [75:0] got, input logic [75:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [7:0] enc8(input longint v);
`ifdef GPS2UTC_BCD_EN
        return {4'(v / 10), 4'(v % 10)};
`else
        return 8'(v);
`endif
    endfunction

    function automatic logic [11:0] enc12(input longint v);
`ifdef GPS2UTC_BCD_EN
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
`else
        return 12'(v);
`endif
    endfunction

    function automatic logic [75:0] fields(input longint h, input longint mi, input longint s,
                                           input longint mo, input longint d, input longint dy,
                                           input longint y);
        return {enc8(h), enc8(mi), enc8(s), enc8(mo), enc8(d), enc12(dy), enc8(y % 100), 16'(y)};
    endfunction

    function automatic logic [75:0] pk(input int g);
        return {hh_o[g], mm_o[g], ss_o[g], mon_o[g], dom_o[g], doy_o[g], yy_o[g], year_o[g]};
    endfunction

    // Reference: seconds arithmetic, then days-since-1970 -> civil date (era/March-based algorithm)
    task automatic model(input int g, input longint wn, input longint tow, input longint lp);
        longint e, gps, utc, days, sod, z, era, doe, yoe, yr, dy, mp, dd, mo, doy;
        longint cum[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
        bit     lpy;
        e = (g == 1) ? 0 : 2;
        if (g == 2 && wn < 512) e = (e == 3) ? 3 : e + 1;
        gps = (e * 1024 + wn) * 604800 + tow;
        if (tow > 604799 || gps < lp) begin
            exp_err[g] = 1'b1;
            exp_lat[g] = 2;
            return;
        end
        utc  = gps - lp;
        days = utc / 86400;
        sod  = utc % 86400;
        z    = days + 3657 + 719468;
        era  = z / 146097;
        doe  = z - era * 146097;
        yoe  = (doe - doe / 1460 + doe / 36524 - doe / 146096) / 365;
        yr   = yoe + era * 400;
        dy   = doe - (365 * yoe + yoe / 4 - yoe / 100);
        mp   = (5 * dy + 2) / 153;
        dd   = dy - (153 * mp + 2) / 5 + 1;
        mo   = (mp < 10) ? mp + 3 : mp - 9;
        if (mo <= 2) yr++;
        lpy  = (yr % 4 == 0) && ((yr % 100 != 0) || (yr % 400 == 0));
        doy  = cum[mo - 1] + dd + ((lpy && mo > 2) ? 1 : 0);
        exp_err[g]  = 1'b0;
        exp_lat[g]  = 37 + int'(yr - 1980) + int'(mo - 1) + BCD_LAT;
        exp_pack[g] = fields(sod / 3600, (sod % 3600) / 60, sod % 60, mo, dd, doy, yr);
    endtask

    // mode 0: plain conversion, 1: extra start while busy, 2: reset at cycle 20
    task automatic run_conv(input logic [9:0] wn, input logic [19:0] tow, input logic [7:0] lp,
                            input int mode);
        int vcnt[3];
        for (int g = 0; g < 3; g++) begin
            model(g, longint'(wn), longint'(tow), longint'(lp));
            vcnt[g]     = 0;
            lat_seen[g] = -1;
        end
        @(posedge clk); #1;
        wn10 = wn; tow_sec = tow; leap_sec = lp; start = 1'b1;
        for (int cyc = 1; cyc <= CYC_BUDGET; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 1 && cyc == 10) begin
                start = 1'b1;
                wn10  = ~wn;
            end
            if (mode == 2 && cyc == 20) rst = 1'b1;
            if (mode == 2 && cyc == 21) begin
                rst = 1'b0;
                check_eq("rst_busy", 76'(busy_o[0]), 76'd0);
                check_eq("rst_fields", pk(0), 76'd0);
            end
            if (cyc == 1) check_eq("busy_c1", 76'(busy_o[0]), 76'd1);
            for (int g = 0; g < 3; g++) begin
                if (valid_o[g]) begin
                    vcnt[g]++;
                    if (lat_seen[g] < 0) lat_seen[g] = cyc;
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            if (mode == 2) begin
                exp_pack[g] = 76'd0;
                exp_err[g]  = 1'b0;
                check_eq($sformatf("rst_nvalid%0d", g), 76'(vcnt[g]), 76'd0);
            end else begin
                check_eq($sformatf("nvalid%0d", g), 76'(vcnt[g]), 76'd1);
                check_eq($sformatf("latency%0d", g), 76'(lat_seen[g]), 76'(exp_lat[g]));
            end
            check_eq($sformatf("fields%0d", g), pk(g), exp_pack[g]);
            check_eq($sformatf("err%0d", g), 76'(err_o[g]), 76'(exp_err[g]));
            check_eq($sformatf("idle%0d", g), 76'(busy_o[g]), 76'd0);
        end
    endtask

    initial begin
        int w, t, l;
        rst = 1'b1; start = 1'b0; wn10 = 10'd0; tow_sec = 20'd0; leap_sec = 8'd0;
        for (int g = 0; g < 3; g++) begin
            exp_pack[g] = 76'd0;
            exp_err[g]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_fields", pk(0), 76'd0);
        check_eq("reset_ctl", {73'd0, busy_o[0], valid_o[0], err_o[0]}, 76'd0);
        rst = 1'b0;

        run_conv(10'd0, 20'd0, 8'd18, 0);
        check_eq("t1_fields", pk(0), fields(23, 59, 42, 4, 6, 96, 2019));
        check_eq("t1_latency", 76'(lat_seen[0]), 76'(79 + BCD_LAT));
        check_eq("t4_err_epoch0", 76'(err_o[1]), 76'd1);
        check_eq("t4_err_latency", 76'(lat_seen[1]), 76'd2);

        run_conv(10'd255, 20'd388818, 8'd18, 0);
        check_eq("t2_leapday", pk(0), fields(12, 0, 0, 2, 29, 60, 2024));

        run_conv(10'd247, 20'd86417, 8'd18, 0);
        check_eq("t3_dec31", pk(0), fields(23, 59, 59, 12, 31, 365, 2023));
        run_conv(10'd247, 20'd86418, 8'd18, 0);
        check_eq("t3_jan1", pk(0), fields(0, 0, 0, 1, 1, 1, 2024));

        run_conv(10'd0, 20'd604800, 8'd18, 0);
        check_eq("t4_tow_range", 76'(err_o[0]), 76'd1);

        run_conv(10'd100, 20'd0, 8'd18, 0);
        check_eq("t6_pivot", pk(2), fields(23, 59, 42, 10, 20, 294, 2040));
        check_eq("t6_nopivot", pk(0), fields(23, 59, 42, 3, 6, 65, 2021));

        run_conv(10'd300, 20'd1000, 8'd18, 1);
        run_conv(10'd300, 20'd1000, 8'd18, 2);

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                w = 0;
                t = int'($urandom_range(0, 300));
                l = int'($urandom_range(0, 255));
            end else begin
                w = int'($urandom_range(0, 1023));
                t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(604800, 1048575))
                                                : int'($urandom_range(0, 604799));
                l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 40));
            end
            run_conv(10'(w), 20'(t), 8'(l), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
